// File: rtl/stim_gen.sv
// Operand stimulus generator: optional corner table, then dual-LFSR random or linear sweep
// vectors, plus a saturating count of monitor mismatch events. Corner table built only with STIM_CORNER_EN.
module stim_gen #(
    parameter int WIDTH        = 32,
    parameter int NUM_VECTORS  = 1024,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [1:0]       i_mode,
    input  logic [31:0]      i_seed,
    input  logic             i_event,
    output logic [WIDTH-1:0] o_dut_ia,
    output logic [WIDTH-1:0] o_dut_ib,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [15:0]      o_err_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CORNER = 3'd1;
    localparam logic [2:0] S_GEN    = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
    localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYCLES);
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [31:0] SEED_B_XOR = 32'hA5A5_A5A5;

    logic [2:0]  state_reg, state_next;
    logic [15:0] idx_reg, idx_next;
    logic [7:0]  drain_reg, drain_next;
    logic        sweep_reg, sweep_next;
    logic [31:0] seed_reg, seed_next;
    logic [31:0] lfsr_a_reg, lfsr_a_next;
    logic [31:0] lfsr_b_reg, lfsr_b_next;
    logic [31:0] ia_reg, ia_next;
    logic [31:0] ib_reg, ib_next;
    logic        valid_reg, valid_next;
    logic [15:0] err_reg, err_next;
    logic        corner_sel;
    logic [31:0] seed_b_raw;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

`ifdef STIM_CORNER_EN
    function automatic logic [63:0] corner_vec(input logic [2:0] i);
        case (i)
            3'd0:    return {32'h0000_0000, 32'h0000_0000};
            3'd1:    return {32'h0000_0000, 32'h0000_0001};
            3'd2:    return {32'h0000_0001, 32'h0000_0000};
            3'd3:    return {32'hFFFF_FFFF, 32'h0000_0001};
            3'd4:    return {32'h7FFF_FFFF, 32'h0000_0001};
            3'd5:    return {32'h8000_0000, 32'hFFFF_FFFF};
            3'd6:    return {32'hFFFF_FFFF, 32'hFFFF_FFFF};
            default: return {32'hAAAA_AAAA, 32'h5555_5555};
        endcase
    endfunction
    assign corner_sel = (i_mode == 2'd1);
`else
    assign corner_sel = 1'b0;
`endif

    assign seed_b_raw = i_seed ^ SEED_B_XOR;

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        drain_next  = drain_reg;
        sweep_next  = sweep_reg;
        seed_next   = seed_reg;
        lfsr_a_next = lfsr_a_reg;
        lfsr_b_next = lfsr_b_reg;
        ia_next     = 32'd0;
        ib_next     = 32'd0;
        valid_next  = 1'b0;
        err_next    = err_reg;
        if (o_busy && i_event && (err_reg != 16'hFFFF))
            err_next = err_reg + 16'd1;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    seed_next   = i_seed;
                    sweep_next  = (i_mode == 2'd2);
                    lfsr_a_next = (i_seed == 32'd0) ? 32'd1 : i_seed;
                    lfsr_b_next = (seed_b_raw == 32'd0) ? 32'd1 : seed_b_raw;
                    idx_next    = 16'd0;
                    drain_next  = 8'd0;
                    err_next    = 16'd0;
                    state_next  = corner_sel ? S_CORNER : S_GEN;
                end
            end
`ifdef STIM_CORNER_EN
            S_CORNER: begin
                {ia_next, ib_next} = corner_vec(idx_reg[2:0]);
                valid_next = 1'b1;
                idx_next   = idx_reg + 16'd1;
                if (idx_reg == LAST_IDX)
                    state_next = S_DRAIN;
                else if (idx_reg == 16'd7)
                    state_next = S_GEN;
            end
`endif
            S_GEN: begin
                valid_next = 1'b1;
                // Sweep keeps seed B fixed; the LFSRs step only in random modes.
                if (sweep_reg) begin
                    ia_next = seed_reg + 32'(idx_reg);
                    ib_next = lfsr_b_reg;
                end else begin
                    ia_next     = lfsr_a_reg;
                    ib_next     = lfsr_b_reg;
                    lfsr_a_next = lfsr_step(lfsr_a_reg);
                    lfsr_b_next = lfsr_step(lfsr_b_reg);
                end
                idx_next = idx_reg + 16'd1;
                if (idx_reg == LAST_IDX)
                    state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (drain_reg == DRAIN_LAST)
                    state_next = S_DONE;
                else
                    drain_next = drain_reg + 8'd1;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            idx_reg    <= 16'd0;
            drain_reg  <= 8'd0;
            sweep_reg  <= 1'b0;
            seed_reg   <= 32'd0;
            lfsr_a_reg <= 32'd0;
            lfsr_b_reg <= 32'd0;
            ia_reg     <= 32'd0;
            ib_reg     <= 32'd0;
            valid_reg  <= 1'b0;
            err_reg    <= 16'd0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            drain_reg  <= drain_next;
            sweep_reg  <= sweep_next;
            seed_reg   <= seed_next;
            lfsr_a_reg <= lfsr_a_next;
            lfsr_b_reg <= lfsr_b_next;
            ia_reg     <= ia_next;
            ib_reg     <= ib_next;
            valid_reg  <= valid_next;
            err_reg    <= err_next;
        end
    end

    assign o_dut_ia    = ia_reg;
    assign o_dut_ib    = ib_reg;
    assign o_valid     = valid_reg;
    assign o_busy      = (state_reg == S_CORNER) || (state_reg == S_GEN) || (state_reg == S_DRAIN);
    assign o_done      = (state_reg == S_DONE);
    assign o_err_count = err_reg;

endmodule

// File: tb/tb_stim_gen.sv
// Bench for stim_gen: two instances (long run and truncated run) checked every cycle
// against a per-vector reference model, plus directed table and reset/event sequences.
module tb_stim_gen;

    localparam int NV_B = 10;
    localparam int D_B  = 8;
    localparam int NV_S = 5;
    localparam int D_S  = 3;

    logic        clk = 1'b0;
    logic        reset, i_start, i_event;
    logic [1:0]  i_mode;
    logic [31:0] i_seed;
    logic [31:0] ia_b, ib_b, ia_s, ib_s;
    logic        valid_b, busy_b, done_b, valid_s, busy_s, done_s;
    logic [15:0] err_b, err_s;

    int errors = 0;
    int checks = 0;
    logic [31:0] cap_a [NV_B];
    logic [31:0] cap_b [NV_B];

    logic [63:0] corner_tbl [8] = '{
        {32'h0000_0000, 32'h0000_0000}, {32'h0000_0000, 32'h0000_0001},
        {32'h0000_0001, 32'h0000_0000}, {32'hFFFF_FFFF, 32'h0000_0001},
        {32'h7FFF_FFFF, 32'h0000_0001}, {32'h8000_0000, 32'hFFFF_FFFF},
        {32'hFFFF_FFFF, 32'hFFFF_FFFF}, {32'hAAAA_AAAA, 32'h5555_5555}};

    stim_gen #(.WIDTH(32), .NUM_VECTORS(NV_B), .DRAIN_CYCLES(D_B)) u_dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_seed(i_seed),
        .i_event(i_event), .o_dut_ia(ia_b), .o_dut_ib(ib_b), .o_valid(valid_b),
        .o_busy(busy_b), .o_done(done_b), .o_err_count(err_b));

    stim_gen #(.WIDTH(32), .NUM_VECTORS(NV_S), .DRAIN_CYCLES(D_S)) u_dut_short (
        .clk(clk), .reset(reset), .i_start(i_start), .i_mode(i_mode), .i_seed(i_seed),
        .i_event(i_event), .o_dut_ia(ia_s), .o_dut_ib(ib_s), .o_valid(valid_s),
        .o_busy(busy_s), .o_done(done_s), .o_err_count(err_s));

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Vector j of a run: table entry, LFSR state after n steps, or seed + j.
    function automatic logic [63:0] exp_vec(input logic [1:0] mode, input logic [31:0] seed, input int j);
        logic [31:0] a, b;
        bit corner;
        int n;
        corner = 1'b0;
`ifdef STIM_CORNER_EN
        corner = (mode == 2'd1);
`endif
        a = (seed == 32'd0) ? 32'd1 : seed;
        b = seed ^ 32'hA5A5_A5A5;
        if (b == 32'd0) b = 32'd1;
        if (mode == 2'd2) return {seed + 32'(j), b};
        if (corner && j < 8) return corner_tbl[j];
        n = corner ? j - 8 : j;
        for (int t = 0; t < n; t++) begin
            a = lfsr_next(a);
            b = lfsr_next(b);
        end
        return {a, b};
    endfunction

    // Expected {valid, busy, done, A, B, count} k cycles after the start edge.
    function automatic logic [82:0] expect_out(input logic [1:0] mode, input logic [31:0] seed,
                                               input int k, input int nv, input int d, input int cnt);
        bit v;
        logic [63:0] vec;
        v   = (k >= 1) && (k <= nv);
        vec = v ? exp_vec(mode, seed, k - 1) : 64'd0;
        return {v, (k <= nv + d), (k > nv + d), vec, 16'(cnt)};
    endfunction

    task automatic check_val(input string name, input logic [82:0] got, input logic [82:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end else begin
            $display("ok   %s %h", name, got);
        end
    endtask

    task automatic run_vectors(input logic [1:0] mode, input logic [31:0] seed, input int ev_sel);
        int cnt_b, cnt_s;
        cnt_b = 0;
        cnt_s = 0;
        @(negedge clk);
        i_mode  = mode;
        i_seed  = seed;
        i_start = 1'b1;
        i_event = 1'b1;
        for (int k = 0; k <= NV_B + D_B + 3; k++) begin
            @(negedge clk);
            check_val($sformatf("long m%0d s%h k%0d", mode, seed, k),
                      {valid_b, busy_b, done_b, ia_b, ib_b, err_b},
                      expect_out(mode, seed, k, NV_B, D_B, cnt_b));
            check_val($sformatf("short m%0d s%h k%0d", mode, seed, k),
                      {valid_s, busy_s, done_s, ia_s, ib_s, err_s},
                      expect_out(mode, seed, k, NV_S, D_S, cnt_s));
            if (k >= 1 && k <= NV_B) begin
                cap_a[k-1] = ia_b;
                cap_b[k-1] = ib_b;
            end
            i_start = (k <= NV_S + D_S) && ($urandom_range(0, 3) == 0);
            i_mode  = 2'($urandom);
            i_seed  = $urandom;
            case (ev_sel)
                1:       i_event = ($urandom_range(0, 2) == 0);
                2:       i_event = (k == 2 || k == 4 || k == 6 || k == 14 || k == 20);
                default: i_event = 1'b0;
            endcase
            if (i_event && k <= NV_B + D_B) cnt_b++;
            if (i_event && k <= NV_S + D_S) cnt_s++;
        end
        i_start = 1'b0;
        i_event = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] seed;
        int          idx;
        logic [31:0] a;
        logic [31:0] b;
    } vec_rec_t;

    vec_rec_t tbl [$];

    initial begin
        tbl.push_back('{2'd0, 32'h0000_0000, 0, 32'h0000_0001, 32'hA5A5_A5A5});
        tbl.push_back('{2'd0, 32'h0000_0000, 1, 32'h8020_0003, 32'hD2F2_D2D1});
        tbl.push_back('{2'd2, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFE, 32'h5A5A_5A5B});
        tbl.push_back('{2'd2, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFF, 32'h5A5A_5A5B});
        tbl.push_back('{2'd2, 32'hFFFF_FFFE, 2, 32'h0000_0000, 32'h5A5A_5A5B});
        tbl.push_back('{2'd3, 32'h0000_0000, 1, 32'h8020_0003, 32'hD2F2_D2D1});
`ifdef STIM_CORNER_EN
        tbl.push_back('{2'd1, 32'h0000_0000, 0, 32'h0000_0000, 32'h0000_0000});
        tbl.push_back('{2'd1, 32'h0000_0000, 3, 32'hFFFF_FFFF, 32'h0000_0001});
        tbl.push_back('{2'd1, 32'h0000_0000, 5, 32'h8000_0000, 32'hFFFF_FFFF});
        tbl.push_back('{2'd1, 32'h0000_0000, 7, 32'hAAAA_AAAA, 32'h5555_5555});
        tbl.push_back('{2'd1, 32'h0000_0000, 8, 32'h0000_0001, 32'hA5A5_A5A5});
        tbl.push_back('{2'd1, 32'h0000_0000, 9, 32'h8020_0003, 32'hD2F2_D2D1});
`else
        tbl.push_back('{2'd1, 32'h0000_0000, 1, 32'h8020_0003, 32'hD2F2_D2D1});
`endif

        reset = 1'b1; i_start = 1'b0; i_event = 1'b0; i_mode = 2'd0; i_seed = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_val($sformatf("idle long c%0d", c), {valid_b, busy_b, done_b, ia_b, ib_b, err_b}, 83'd0);
            check_val($sformatf("idle short c%0d", c), {valid_s, busy_s, done_s, ia_s, ib_s, err_s}, 83'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            if (i == 0 || tbl[i].mode != tbl[i-1].mode || tbl[i].seed != tbl[i-1].seed)
                run_vectors(tbl[i].mode, tbl[i].seed, 0);
            check_val($sformatf("table m%0d s%h v%0d", tbl[i].mode, tbl[i].seed, tbl[i].idx),
                      {19'd0, cap_a[tbl[i].idx], cap_b[tbl[i].idx]},
                      {19'd0, tbl[i].a, tbl[i].b});
        end

        run_vectors(2'd0, 32'h1234_5678, 2);
        @(negedge clk);
        check_val("event count after done", {67'd0, err_b}, {67'd0, 16'd4});

        repeat (6) run_vectors(2'($urandom_range(0, 3)), $urandom, 1);

        @(negedge clk);
        i_mode = 2'd0; i_seed = 32'hCAFE_0001; i_start = 1'b1; i_event = 1'b0;
        @(negedge clk);
        i_start = 1'b0; i_event = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1; i_event = 1'b0;
        @(negedge clk);
        check_val("reset mid-run long", {valid_b, busy_b, done_b, ia_b, ib_b, err_b}, 83'd0);
        check_val("reset mid-run short", {valid_s, busy_s, done_s, ia_s, ib_s, err_s}, 83'd0);
        reset = 1'b0;
        run_vectors(2'd0, 32'hCAFE_0001, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
